// File: rtl/bcd2bin_seq_pkg.sv
// Shared definitions for the packed-BCD to binary converter.
//   ST_IDLE / ST_SHIFT / ST_DONE : FSM state encodings
//   bin_width(digits)            : bits needed to hold 10**digits - 1
package bcd2bin_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Equivalent to $clog2(10**digits), computed in 64 bits so DIGITS=9 cannot overflow.
    function automatic int unsigned bin_width(input int unsigned digits);
        longint unsigned p;
        int unsigned     w;
        p = 64'd1;
        w = 0;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        while ((64'd1 << w) < p) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: after the right shift, any BCD digit that
// reads 8 or more had a 1 shifted in from the digit above (worth 5 after halving,
// but 8 in binary), so 3 is taken off.
//   din  : post-shift 4-bit digit
//   dout : corrected digit (inputs above 12 cannot occur and are don't-care)
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd2bin_seq.sv
// Iterative packed-BCD to binary converter, one result bit per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a conversion (ignored while busy)
//   bcd_in     : packed BCD operand, digit 0 in [3:0]; captured on accept
//   sign_in    : 1 = negative; captured on accept (ignored when SIGNED=0)
//   busy       : conversion in progress
//   done       : one-cycle pulse, result/err valid
//   err        : last accepted request contained a digit > 9
//   result     : binary result (two's complement when SIGNED=1), held until next accept
module bcd2bin_seq
    import bcd2bin_seq_pkg::*;
#(
    parameter  int unsigned DIGITS = 4,
    parameter  int unsigned SIGNED = 1,
    localparam int unsigned BIN_W  = bin_width(DIGITS),
    localparam int unsigned OUT_W  = BIN_W + SIGNED
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                sign_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [OUT_W-1:0]    result
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    logic [1:0]       state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             err_q, err_d;
    logic [OUT_W-1:0] result_q, result_d;

    logic [SR_W-1:0]  sr_shift;
    logic [SR_W-1:0]  sr_next;
    logic [BCD_W-1:0] bcd_adj;
    logic [OUT_W-1:0] mag_ext;
    logic             bad_digit;
    logic             last_shift;

    // Shift right first, then correct each BCD digit; the BCD LSB lands in the binary MSB.
    assign sr_shift = sr_q >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (sr_shift[BIN_W + 4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    assign sr_next    = {bcd_adj, sr_shift[BIN_W-1:0]};
    assign mag_ext    = OUT_W'(sr_next[BIN_W-1:0]);
    assign last_shift = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(1));

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        err_d    = err_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (bad_digit) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        sr_d    = {bcd_in, {BIN_W{1'b0}}};
                        sign_d  = sign_in;
                        cnt_d   = CNT_W'(BIN_W);
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sr_d  = sr_next;
                cnt_d = cnt_q - 1'b1;
                if (last_shift) begin
                    // Negating zero yields zero, so no negative-zero special case.
                    result_d = ((SIGNED != 0) && sign_q) ? (-mag_ext) : mag_ext;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            err_q    <= err_d;
            result_q <= result_d;
            // Every BCD bit must have migrated into the binary half by the final shift.
            if (last_shift) begin
                assert (sr_next[SR_W-1:BIN_W] == '0);
            end
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;

    localparam int OUT_W = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [15:0]       bcd_in = '0;
    logic              sign_in = 1'b0;
    logic              busy, done, err;
    logic [OUT_W-1:0]  result;

    typedef struct packed {
        logic [OUT_W-1:0] res;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    bcd2bin_seq #(.DIGITS(4), .SIGNED(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .sign_in (sign_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: drop start after accept; 1: also pulse start at busy cycles 3 and 10;
    // 2: leave start untouched. Returns edges from start raised to done seen.
    task automatic wait_done(input int mode, output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (mode != 2 && lat == 1) start = 1'b0;
            if (mode == 1) begin
                if (lat == 3 || lat == 10) begin
                    start   = 1'b1;
                    bcd_in  = 16'h8888;
                    sign_in = ~sign_in;
                end else if (lat == 4 || lat == 11) begin
                    start = 1'b0;
                end
            end
            if (done) got = 1'b1;
        end
    endtask

    task automatic check_done(input string tag, input int lat, input bit got, input int exp_lat);
        exp_t e;
        vectors++;
        assert (got) else begin
            miscompares++;
            $error("FAIL %s_timeout: observed no done expected done", tag);
        end
        chk({tag, "_lat"}, lat, exp_lat);
        e = sb.pop_front();
        chk({tag, "_res"}, result, e.res);
        chk({tag, "_err"}, err, e.err);
    endtask

    task automatic run(input string tag, input logic [15:0] bcd, input logic sgn,
                       input logic [OUT_W-1:0] exp_res, input logic exp_err,
                       input int exp_lat, input int mode);
        int lat;
        bit got;
        bcd_in  = bcd;
        sign_in = sgn;
        start   = 1'b1;
        sb.push_back('{res: exp_res, err: exp_err});
        wait_done(mode, lat, got);
        check_done(tag, lat, got, exp_lat);
    endtask

    initial begin
        int lat;
        bit got;
        bit seen;
        logic [15:0] b;
        logic        s;
        logic [OUT_W-1:0] m;

        // Reset state before any clock edge
        #3;
        chk("rst0_busy", busy, 0);
        chk("rst0_done", done, 0);
        chk("rst0_err", err, 0);
        chk("rst0_res", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("max9999", 16'h9999, 1'b0, 15'h270F, 1'b0, 15, 0);
        run("neg125", 16'h0125, 1'b1, 15'h7F83, 1'b0, 15, 0);
        run("negzero", 16'h0000, 1'b1, 15'h0000, 1'b0, 15, 0);
        run("baddig", 16'h12A4, 1'b0, 15'h0000, 1'b1, 1, 0);

        // Asynchronous reset mid-cycle clears err with no clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_err", err, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("after_err", 16'h0042, 1'b0, 15'd42, 1'b0, 15, 0);

        // Starts while busy are ignored
        run("glitch", 16'h1234, 1'b0, 15'd1234, 1'b0, 15, 1);
        @(posedge clk);
        #1;

        // Start held through DONE retriggers with the current bcd_in
        bcd_in  = 16'h0321;
        sign_in = 1'b0;
        start   = 1'b1;
        sb.push_back('{res: 15'd321, err: 1'b0});
        sb.push_back('{res: 15'h7D72, err: 1'b0});
        wait_done(2, lat, got);
        bcd_in  = 16'h0654;
        sign_in = 1'b1;
        check_done("hold1", lat, got, 15);
        chk("hold1_busy", busy, 0);
        wait_done(2, lat, got);
        start = 1'b0;
        check_done("hold2", lat, got, 15);

        // Sampled sweep against an arithmetic reference, some with bad digits
        for (int v = 0; v <= 9999; v += 37) begin
            b = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            s = 1'($urandom_range(0, 1));
            m = OUT_W'(v);
            run("sweep", b, s, s ? (-m) : m, 1'b0, 15, 0);
            if (v % 999 == 0) begin
                b[4 * (v % 4) +: 4] = 4'(10 + (v % 6));
                run("sweep_bad", b, s, 15'd0, 1'b1, 1, 0);
            end
        end
        run("sweep_top", 16'h9999, 1'b1, 15'h58F1, 1'b0, 15, 0);
        @(posedge clk);
        #1;

        // Reset during conversion aborts it silently
        bcd_in  = 16'h5555;
        sign_in = 1'b0;
        start   = 1'b1;
        sb.push_back('{res: 15'd5555, err: 1'b0});
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("abort_busy_pre", busy, 1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_res", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);

        run("post_abort", 16'h0007, 1'b0, 15'd7, 1'b0, 15, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
